// File: rtl/mem_access_pkg.sv
// Shared types and default parameters for the memory access master.
package mem_access_pkg;

    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/mem_rd_timer.sv
// Read-wait counter: loads 1, increments while enabled, flags when it reaches TIMEOUT.
module mem_rd_timer
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_W'(1);
        end else if (inc && !tc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign tc = (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_master.sv
// Single-outstanding-command initiator for the 16x32 memory strobe interface.
// Optional MEM_WRITE_VERIFY_EN: every write is followed by a read-back compare.
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_rw_en,
    output logic              mem_rr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_valid_out,
    output logic              busy
);

    state_e            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              mem_en_q;
    logic              mem_rw_en_q;
    logic              mem_rr_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_in_q;
    logic              busy_q;
    logic              tmr_tc;

`ifdef MEM_WRITE_VERIFY_EN
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
`endif

    mem_rd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state_q == READ_REQ),
        .inc  (state_q == READ_WAIT),
        .tc   (tmr_tc)
    );

    // Outputs are loaded on the transition into a state, so strobes appear in the
    // state's own cycle and drop back to zero by default one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_rw_en_q   <= 1'b0;
            mem_rr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            mem_en_q      <= 1'b0;
            mem_rw_en_q   <= 1'b0;
            mem_rr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= cmd_addr;
`ifdef MEM_WRITE_VERIFY_EN
                        write_q     <= cmd_write;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
`endif
                        if (cmd_write) begin
                            state_q       <= WRITE;
                            mem_rw_en_q   <= 1'b1;
                            mem_data_in_q <= cmd_wdata;
                        end else begin
                            state_q     <= READ_REQ;
                            mem_rr_en_q <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
`ifdef MEM_WRITE_VERIFY_EN
                    state_q     <= READ_REQ;
                    mem_en_q    <= 1'b1;
                    mem_rr_en_q <= 1'b1;
                    mem_addr_q  <= addr_q;
`else
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
`endif
                end
                READ_REQ: begin
                    state_q <= READ_WAIT;
                end
                READ_WAIT: begin
                    if (mem_valid_out) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_data_out;
`ifdef MEM_WRITE_VERIFY_EN
                        rsp_err_q   <= write_q && (mem_data_out != wdata_q);
`else
                        rsp_err_q   <= 1'b0;
`endif
                    end else if (tmr_tc) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_en      = mem_en_q;
    assign mem_rw_en   = mem_rw_en_q;
    assign mem_rr_en   = mem_rr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master; also exercises MEM_WRITE_VERIFY_EN when defined.
module tb_mem_access_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_rw_en, mem_rr_en;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data_in, mem_data_out;
    logic        mem_valid_out;
    logic        busy;

    mem_access_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_en        (mem_en),
        .mem_rw_en     (mem_rw_en),
        .mem_rr_en     (mem_rr_en),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out),
        .mem_valid_out (mem_valid_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        int          l;
        logic [31:0] cor;
        int          k;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    typedef struct {
        int          k;
        logic [31:0] rd;
        logic        er;
        logic        t1_rw, t1_rr;
        logic [3:0]  t1_addr;
        logic [31:0] t1_data;
        int          nwr, nrd;
        logic [3:0]  rd_addr;
    } res_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_arr [16];
    logic [31:0] ref_mem [16];
    int          mem_lat;
    logic [31:0] mem_corrupt;
    bit          resp_busy;
    logic [31:0] resp_d;
    int          resp_l;
    int          nwr = 0, nrd = 0, n_rsp_hs = 0, n_viol = 0, n_exp_rsp = 0;
    logic [3:0]  last_rd_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory device: stores writes, counts strobes and flags interface rule breaks.
    always @(negedge clk) begin
        if (mem_en && mem_rw_en) begin
            nwr++;
            mem_arr[mem_addr] = mem_data_in;
        end
        if (mem_en && mem_rr_en) begin
            nrd++;
            last_rd_addr = mem_addr;
        end
        if (rsp_valid && rsp_ready) n_rsp_hs++;
        if ((mem_rw_en && mem_rr_en) || ((mem_rw_en || mem_rr_en) != mem_en) ||
            (!mem_rw_en && !mem_rr_en && (mem_addr != 4'h0 || mem_data_in != 32'h0)))
            n_viol++;
    end

    // Read responder: Valid_out lands L cycles after the read strobe cycle.
    initial begin
        mem_valid_out = 1'b0;
        mem_data_out  = '0;
        resp_busy     = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_en && mem_rr_en && mem_lat > 0) begin
                resp_d    = mem_arr[mem_addr] ^ mem_corrupt;
                resp_l    = mem_lat;
                resp_busy = 1'b1;
                repeat (resp_l) @(posedge clk);
                #1;
                mem_valid_out = 1'b1;
                mem_data_out  = resp_d;
                @(posedge clk);
                #1;
                mem_valid_out = 1'b0;
                mem_data_out  = '0;
                resp_busy     = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: response cycle offset k (from accept cycle T), data and error.
    function automatic void model(input logic w, input logic [3:0] a, input logic [31:0] d,
                                  input int l, input logic [31:0] cor,
                                  output int k, output logic [31:0] rd, output logic er);
        logic [31:0] back;
        int          base;
        bit          arrives;
        if (w) ref_mem[a] = d;
        arrives = (l >= 1) && (l <= TO);
        back    = ref_mem[a] ^ cor;
`ifndef MEM_WRITE_VERIFY_EN
        if (w) begin
            k = 2; rd = '0; er = 1'b0;
            return;
        end
`endif
        base = w ? 3 : 2;
        if (arrives) begin
            k = base + l; rd = back; er = w && (back != d);
        end else begin
            k = base + TO; rd = '0; er = 1'b1;
        end
    endfunction

    task automatic wait_mem_idle();
        int n = 0;
        while (resp_busy && n < 50) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic run_cmd(input logic w, input logic [3:0] a, input logic [31:0] d, input int l,
                           input logic [31:0] cor, input int hold, output res_t r);
        int n;
        int wr0, rd0;
        r.k = -1; r.rd = 'x; r.er = 'x; r.t1_rw = 'x; r.t1_rr = 'x;
        r.t1_addr = 'x; r.t1_data = 'x; r.nwr = -1; r.nrd = -1; r.rd_addr = 'x;
        wait_mem_idle();
        mem_lat = l; mem_corrupt = cor;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        wr0 = nwr; rd0 = nrd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        r.t1_rw = mem_rw_en; r.t1_rr = mem_rr_en; r.t1_addr = mem_addr; r.t1_data = mem_data_in;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!rsp_valid) return;
        r.k = n; r.rd = rsp_rdata; r.er = rsp_err;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_exp_rsp++;
        r.nwr = nwr - wr0; r.nrd = nrd - rd0; r.rd_addr = last_rd_addr;
    endtask

    vec_t        vt [10];
    res_t        r;
    int          ek;
    logic [31:0] erd;
    logic        eer;
    logic [31:0] cap_rd;
    logic        cap_er;
    bit          ok;
    int          n;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; mem_lat = 1; mem_corrupt = '0;

        //                w     a     d             l   cor    k   rd            er
        vt[1] = '{1'b0, 4'h3, 32'h0,        1,  32'h0, 3,  32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b0, 4'h3, 32'h0,        8,  32'h0, 10, 32'hDEADBEEF, 1'b0};
        vt[3] = '{1'b0, 4'h3, 32'h0,        0,  32'h0, 10, 32'h0,        1'b1};
        vt[4] = '{1'b0, 4'h3, 32'h0,        9,  32'h0, 10, 32'h0,        1'b1};
        vt[5] = '{1'b0, 4'h3, 32'h0,        2,  32'hFF, 4, 32'hDEADBE10, 1'b0};
        vt[8] = '{1'b0, 4'hF, 32'h0,        4,  32'h0, 6,  32'h1234,     1'b0};
`ifdef MEM_WRITE_VERIFY_EN
        vt[0] = '{1'b1, 4'h3, 32'hDEADBEEF, 1,  32'h0, 4,  32'hDEADBEEF, 1'b0};
        vt[6] = '{1'b1, 4'hF, 32'h1234,     1,  32'h1, 4,  32'h1235,     1'b1};
        vt[7] = '{1'b1, 4'hF, 32'h1234,     3,  32'h0, 6,  32'h1234,     1'b0};
        vt[9] = '{1'b1, 4'h0, 32'hA5A5A5A5, 9,  32'h0, 11, 32'h0,        1'b1};
`else
        vt[0] = '{1'b1, 4'h3, 32'hDEADBEEF, 1,  32'h0, 2,  32'h0,        1'b0};
        vt[6] = '{1'b1, 4'hF, 32'h1234,     1,  32'h1, 2,  32'h0,        1'b0};
        vt[7] = '{1'b1, 4'hF, 32'h1234,     3,  32'h0, 2,  32'h0,        1'b0};
        vt[9] = '{1'b1, 4'h0, 32'hA5A5A5A5, 9,  32'h0, 2,  32'h0,        1'b0};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl", {cmd_ready, rsp_valid, rsp_err, busy, mem_en, mem_rw_en, mem_rr_en}, 64'h0);
        check("reset data", {mem_addr, mem_data_in}, 64'h0);
        check("reset rdata", rsp_rdata, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready after reset", cmd_ready, 64'h1);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_cmd(vt[i].w, vt[i].a, vt[i].d, vt[i].l, vt[i].cor, i % 3, r);
            model(vt[i].w, vt[i].a, vt[i].d, vt[i].l, vt[i].cor, ek, erd, eer);
            check($sformatf("vec%0d latency", i), 64'(r.k), 64'(vt[i].k));
            check($sformatf("vec%0d rdata", i), r.rd, vt[i].rd);
            check($sformatf("vec%0d err", i), r.er, vt[i].er);
            if (vt[i].w) begin
                check($sformatf("vec%0d wr strobe", i), {r.t1_rw, r.t1_rr, r.t1_addr, r.t1_data},
                      {1'b1, 1'b0, vt[i].a, vt[i].d});
`ifdef MEM_WRITE_VERIFY_EN
                check($sformatf("vec%0d pulses", i), 64'(r.nwr * 256 + r.nrd), 64'(257));
                check($sformatf("vec%0d verify addr", i), r.rd_addr, vt[i].a);
`else
                check($sformatf("vec%0d pulses", i), 64'(r.nwr * 256 + r.nrd), 64'(256));
`endif
            end else begin
                check($sformatf("vec%0d rd strobe", i), {r.t1_rw, r.t1_rr, r.t1_addr},
                      {1'b0, 1'b1, vt[i].a});
                check($sformatf("vec%0d pulses", i), 64'(r.nwr * 256 + r.nrd), 64'(1));
            end
        end

        // Response back-pressure with a queued command waiting
        wait_mem_idle();
        mem_lat = 2; mem_corrupt = '0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3; cmd_wdata = '0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 32'h55;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        model(1'b0, 4'h3, 32'h0, 2, 32'h0, ek, erd, eer);
        check("bp latency", 64'(n), 64'(ek));
        check("bp rdata", rsp_rdata, erd);
        cap_rd = rsp_rdata; cap_er = rsp_err;
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== cap_rd || rsp_err !== cap_er || cmd_ready || mem_en) ok = 1'b0;
        end
        check("bp hold stable", ok, 64'h1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp ready next", cmd_ready, 64'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp next accepted", {mem_en, mem_rw_en, mem_addr, mem_data_in}, {1'b1, 1'b1, 4'h5, 32'h55});
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        model(1'b1, 4'h5, 32'h55, 2, 32'h0, ek, erd, eer);
        check("bp second err", rsp_err, eer);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_exp_rsp += 2;

        // Reset during READ_WAIT, then a late Valid_out
        wait_mem_idle();
        mem_lat = 6;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("busy in wait", busy, 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort ctl", {cmd_ready, rsp_valid, rsp_err, busy, mem_en, mem_rw_en, mem_rr_en}, 64'h0);
        check("abort data", {rsp_rdata, mem_addr, mem_data_in[27:0]}, 64'h0);
        ok = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid || busy || mem_en) ok = 1'b0;
        end
        check("late valid ignored", ok, 64'h1);
        run_cmd(1'b1, 4'hF, 32'h1, 1, 32'h0, 0, r);
        model(1'b1, 4'hF, 32'h1, 1, 32'h0, ek, erd, eer);
        check("post-reset latency", 64'(r.k), 64'(ek));
        check("post-reset rsp", {r.rd, r.er}, {erd, eer});

        // Randomized commands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [3:0]  a;
            logic [31:0] d, cor;
            int          l, hold;
            w    = 1'($urandom_range(0, 1));
            a    = 4'($urandom_range(0, 15));
            d    = $urandom();
            l    = $urandom_range(0, TO + 2);
            cor  = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            hold = $urandom_range(0, 3);
            model(w, a, d, l, cor, ek, erd, eer);
            run_cmd(w, a, d, l, cor, hold, r);
            check($sformatf("rnd%0d latency", i), 64'(r.k), 64'(ek));
            check($sformatf("rnd%0d rdata", i), r.rd, erd);
            check($sformatf("rnd%0d err", i), r.er, eer);
        end

        repeat (15) @(posedge clk);
        #1;
        check("response count", 64'(n_rsp_hs), 64'(n_exp_rsp));
        check("strobe rules", 64'(n_viol), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
Initiator for the 16x32 single-port memory's En/Rw_en/Rr_en/Address/Data_in/Data_out/Valid_out interface. It accepts one command at a time from an upstream valid/ready port and drives the memory strobes. For reads, it waits for Valid_out with a bounded timeout. It returns one response per command on a valid/ready response port. It sits between the test/controller logic and the memory as the counterpart that issues requests.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 32, memory data width
TIMEOUT, 8, maximum READ_WAIT cycles allowed for Valid_out (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  1=timeout or verify mismatch
mem_en  out  1  memory enable (En)
mem_rw_en  out  1  write strobe (Rw_en)
mem_rr_en  out  1  read strobe (Rr_en)
mem_addr  out  ADDR_W  Address
mem_data_in  out  DATA_W  Data_in
mem_data_out  in  DATA_W  Data_out
mem_valid_out  in  1  Valid_out
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE; cmd_ready=0 while rst is high, 1 in the first cycle after release; every other output 0.
- FSM states are IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake at cycle T, latch cmd_write, cmd_addr and cmd_wdata.
  - Next state is WRITE or READ_REQ.
- WRITE (cycle T+1):
  - mem_en=1, mem_rw_en=1, mem_addr=addr, mem_data_in=wdata for exactly one cycle.
  - Next state is RESP, with rdata=0 and err=0.
- READ_REQ (cycle T+1):
  - mem_en=1, mem_rr_en=1, mem_addr=addr for exactly one cycle.
  - Next state is READ_WAIT and the wait counter loads 1.
- READ_WAIT:
  - Strobes are 0.
  - If mem_valid_out=1, capture mem_data_out and go to RESP with err=0.
  - Otherwise, if counter==TIMEOUT, go to RESP with err=1 and rdata=0.
  - Otherwise, increment the counter.
  - The counter width is $clog2(TIMEOUT+1).
- Memory latency L (Valid_out at T+1+L):
  - Accepted when 1<=L<=TIMEOUT.
  - Timeout when L>TIMEOUT.
  - mem_valid_out in any state other than READ_WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On handshake, return to IDLE; cmd_ready=1 the following cycle.
  - rsp_valid is never combinationally dependent on rsp_ready.
- Idle outputs: mem_addr and mem_data_in are 0 whenever no strobe is active. mem_rw_en and mem_rr_en are never both 1.
- cmd_ready=0 in every state except IDLE, so there is at most one outstanding command.
- Latency:
  - Write: rsp_valid at T+2.
  - Read: rsp_valid at T+2+L, or T+2+TIMEOUT on timeout.
- Reset mid-operation: aborts the command at the next edge. Strobes drop, any pending response is discarded, and a late Valid_out is ignored.

Optional Feature:
- Macro: MEM_WRITE_VERIFY_EN.
- When defined:
  - After WRITE, the FSM goes to READ_REQ at the same address, then READ_WAIT.
  - The response carries the read-back data in rsp_rdata.
  - err=1 on timeout or when the read-back data differs from wdata.
  - Write latency becomes T+3+L.
- When undefined: writes respond directly from WRITE as specified above.

Decomposition:
- Package mem_access_pkg holds:
  - the state_e enum (IDLE, WRITE, READ_REQ, READ_WAIT, RESP)
  - default localparams ADDR_W_DEF=4, DATA_W_DEF=32, TIMEOUT_DEF=8
- One sub-module, mem_rd_timer, is natural: a load/increment/terminal-count counter parameterised by TIMEOUT.
- The FSM stays in the top module.

Test Plan:
1. Write 0xDEADBEEF to addr 0x3, accepted at T -> at T+1, mem_en=1, mem_rw_en=1, mem_addr=3, mem_data_in=DEADBEEF for one cycle only; at T+2, rsp_valid=1, err=0, rdata=0.
2. Read addr 0x3, memory model with L=1 returning DEADBEEF -> mem_rr_en pulses at T+1; at T+3, rsp_valid=1, rdata=DEADBEEF, err=0. Repeat with L=8: response at T+10, err=0.
3. Read with Valid_out never asserted, TIMEOUT=8 -> at T+10, rsp_valid=1, err=1, rdata=0. L=9 also gives err=1, and its late Valid_out does not create a second response.
4. Read completes with rsp_ready held low 5 cycles while cmd_valid stays high -> rsp fields stay stable, cmd_ready=0, no memory strobes; the next command is accepted one cycle after the response handshake.
5. rst pulsed during READ_WAIT -> next cycle all outputs 0 and busy=0; Valid_out arriving later is ignored; a following write of 0x1 to addr 0xF completes normally at T+2.
6. With MEM_WRITE_VERIFY_EN defined, write 0x1234 to addr 0xF and the memory returns 0x1235 -> write pulse, then read pulse at the same address; rsp_err=1, rsp_rdata=0x1235. A matching read-back gives err=0.
